ifid_idex_pipe_regs: RTL and testbench

//  IF/ID and ID/EX pipeline registers plus stall/bubble sequencing for the 5-stage MIPS core.

---
 rtl/ifid_idex_pipe_regs_pkg.sv | 35 +++
 rtl/ifid_idex_pipe_regs_pipe_reg.sv | 24 ++
 rtl/ifid_idex_pipe_regs.sv | 120 ++++++++++++
 tb/tb_ifid_idex_pipe_regs.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_idex_pipe_regs_pkg.sv
// Shared constants, state encodings and stage bundles for the IF/ID and ID/EX registers.
package ifid_idex_pipe_regs_pkg;

    localparam logic [31:0] BUBBLE_IR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_HOLD  = 2'd2
    } stall_state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] FN_ADDU    = 6'h21;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } if_id_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
    } id_ex_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifid_idex_pipe_regs_pipe_reg.sv
// Width-parameterised pipeline register: async reset, synchronous clear, load enable.
module pipe_reg #(
    parameter int         W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] clr_value,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RST_VAL;
        else if (clr)
            q <= clr_value;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ifid_idex_pipe_regs.sv
// IF/ID and ID/EX pipeline registers with load-use bubble, hold and flush sequencing.
// Optional perf counters (bubble_cnt, hold_cnt) when PIPE_PERF_CNT_EN is defined.
module ifid_idex_pipe_regs
    import ifid_idex_pipe_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] BUBBLE_IR = BUBBLE_IR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_ir,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_ext_imm,
    input  logic        nop,
    input  logic        hold,
    input  logic        exc_flush,
    output logic        pc_en,
    output logic [31:0] IFID_IR,
    output logic [31:0] IFID_PC,
    output logic [31:0] IDEX_IR,
    output logic [31:0] IDEX_PC,
    output logic [31:0] IDEX_RS,
    output logic [31:0] IDEX_RT,
    output logic [31:0] IDEX_IMM,
    output logic [1:0]  stall_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] hold_cnt
`endif
);

    localparam if_id_t IFID_RST = '{pc: RESET_PC, ir: BUBBLE_IR};
    localparam id_ex_t IDEX_RST = '{
        ir: BUBBLE_IR, pc: RESET_PC, rs: 32'd0, rt: 32'd0, imm: 32'd0
    };

    if_id_t       ifid_d, ifid_q;
    id_ex_t       idex_d, idex_q;
    stall_state_t state;
    logic         advance;

    assign advance = ~hold & ~nop;
    assign pc_en   = (~hold & ~(nop & ~exc_flush)) | exc_flush;

    always_comb begin
        ifid_d = '{pc: if_pc, ir: if_ir};
        idex_d = '{
            ir: ifid_q.ir, pc: ifid_q.pc,
            rs: id_rs_data, rt: id_rt_data, imm: id_ext_imm
        };
        // Bubble keeps the PC so the slot still traces back to its fetch address
        if (nop)
            idex_d = '{
                ir: BUBBLE_IR, pc: ifid_q.pc,
                rs: 32'd0, rt: 32'd0, imm: 32'd0
            };
    end

    pipe_reg #(.W($bits(if_id_t)), .RST_VAL(IFID_RST)) u_ifid (
        .clk       (clk),
        .reset     (reset),
        .en        (advance),
        .clr       (exc_flush),
        .clr_value (IFID_RST),
        .d         (ifid_d),
        .q         (ifid_q)
    );

    pipe_reg #(.W($bits(id_ex_t)), .RST_VAL(IDEX_RST)) u_idex (
        .clk       (clk),
        .reset     (reset),
        .en        (~hold),
        .clr       (exc_flush),
        .clr_value (IDEX_RST),
        .d         (idex_d),
        .q         (idex_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_RUN;
        else if (exc_flush)
            state <= ST_RUN;
        else if (hold)
            state <= ST_HOLD;
        else if (nop)
            state <= ST_LDUSE;
        else
            state <= ST_RUN;
    end

    assign stall_state = state;
    assign IFID_IR     = ifid_q.ir;
    assign IFID_PC     = ifid_q.pc;
    assign IDEX_IR     = idex_q.ir;
    assign IDEX_PC     = idex_q.pc;
    assign IDEX_RS     = idex_q.rs;
    assign IDEX_RT     = idex_q.rt;
    assign IDEX_IMM    = idex_q.imm;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= 32'd0;
            hold_cnt   <= 32'd0;
        end else if (exc_flush) begin
            bubble_cnt <= 32'd0;
            hold_cnt   <= 32'd0;
        end else if (hold) begin
            hold_cnt <= sat_inc(hold_cnt);
        end else if (nop) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_ifid_idex_pipe_regs.sv
// Scoreboard bench for ifid_idex_pipe_regs: expected register contents queued per edge.
module tb_ifid_idex_pipe_regs;
    import ifid_idex_pipe_regs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc, if_ir, id_rs_data, id_rt_data, id_ext_imm;
    logic        nop, hold, exc_flush;
    logic        pc_en;
    logic [31:0] IFID_IR, IFID_PC, IDEX_IR, IDEX_PC;
    logic [31:0] IDEX_RS, IDEX_RT, IDEX_IMM;
    logic [1:0]  stall_state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] bubble_cnt, hold_cnt;
`endif

    ifid_idex_pipe_regs dut (
        .clk         (clk),
        .reset       (reset),
        .if_pc       (if_pc),
        .if_ir       (if_ir),
        .id_rs_data  (id_rs_data),
        .id_rt_data  (id_rt_data),
        .id_ext_imm  (id_ext_imm),
        .nop         (nop),
        .hold        (hold),
        .exc_flush   (exc_flush),
        .pc_en       (pc_en),
        .IFID_IR     (IFID_IR),
        .IFID_PC     (IFID_PC),
        .IDEX_IR     (IDEX_IR),
        .IDEX_PC     (IDEX_PC),
        .IDEX_RS     (IDEX_RS),
        .IDEX_RT     (IDEX_RT),
        .IDEX_IMM    (IDEX_IMM),
        .stall_state (stall_state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt),
        .hold_cnt    (hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ifid_ir;
        logic [31:0] ifid_pc;
        logic [31:0] idex_ir;
        logic [31:0] idex_pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] st;
        logic [31:0] bcnt;
        logic [31:0] hcnt;
    } exp_t;

    exp_t        m;
    exp_t        sbq[$];
    logic [31:0] hist[$];
    logic [31:0] snap;
    int          checks = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m = '0;
        m.ifid_pc = 32'h0000_3000;
        m.idex_pc = 32'h0000_3000;
        m.st      = 32'd0;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic n, input logic h, input logic f);
        if_ir      = ir;
        if_pc      = pc;
        nop        = n;
        hold       = h;
        exc_flush  = f;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_ext_imm = $urandom;
    endtask

    task automatic step();
        exp_t e;
        logic exp_pc_en;
        #1;
        if (exc_flush)          exp_pc_en = 1'b1;
        else if (hold || nop)   exp_pc_en = 1'b0;
        else                    exp_pc_en = 1'b1;
        check_eq("pc_en", {31'd0, pc_en}, {31'd0, exp_pc_en});
        if (exc_flush) begin
            model_reset();
        end else if (hold) begin
            m.st = 32'd2;
            if (m.hcnt != 32'hffff_ffff) m.hcnt = m.hcnt + 1;
        end else if (nop) begin
            m.idex_ir = 32'd0;
            m.idex_pc = m.ifid_pc;
            m.rs = 0; m.rt = 0; m.imm = 0;
            m.st = 32'd1;
            if (m.bcnt != 32'hffff_ffff) m.bcnt = m.bcnt + 1;
        end else begin
            m.idex_ir = m.ifid_ir;
            m.idex_pc = m.ifid_pc;
            m.rs = id_rs_data; m.rt = id_rt_data; m.imm = id_ext_imm;
            m.ifid_ir = if_ir;
            m.ifid_pc = if_pc;
            m.st = 32'd0;
        end
        sbq.push_back(m);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_eq("IFID_IR", IFID_IR, e.ifid_ir);
        check_eq("IFID_PC", IFID_PC, e.ifid_pc);
        check_eq("IDEX_IR", IDEX_IR, e.idex_ir);
        check_eq("IDEX_PC", IDEX_PC, e.idex_pc);
        check_eq("IDEX_RS", IDEX_RS, e.rs);
        check_eq("IDEX_RT", IDEX_RT, e.rt);
        check_eq("IDEX_IMM", IDEX_IMM, e.imm);
        check_eq("state", {30'd0, stall_state}, e.st);
`ifdef PIPE_PERF_CNT_EN
        check_eq("bubble_cnt", bubble_cnt, e.bcnt);
        check_eq("hold_cnt", hold_cnt, e.hcnt);
`endif
    endtask

    function automatic logic [31:0] ori(input int i);
        return {OP_ORI, 5'd0, 5'(i + 1), 16'(16'h100 + i)};
    endfunction

    initial begin
        logic [31:0] lw_i, addu_i, pc;
        lw_i   = {OP_LW, 5'd0, 5'd1, 16'd0};
        addu_i = {OP_SPECIAL, 5'd1, 5'd1, 5'd2, 5'd0, FN_ADDU};
        drive(32'd0, 32'h3000, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ifid_ir", IFID_IR, 32'd0);
        check_eq("rst_ifid_pc", IFID_PC, 32'h3000);
        check_eq("rst_idex_ir", IDEX_IR, 32'd0);
        check_eq("rst_state", {30'd0, stall_state}, 32'd0);
        reset = 1'b0;

        // independent ori stream
        pc = 32'h3000;
        for (int i = 0; i < 8; i++) begin
            drive(ori(i), pc, 1'b0, 1'b0, 1'b0);
            step();
            hist.push_back(ori(i));
            if (i >= 1) check_eq("stream_delay", IDEX_IR, hist[i-1]);
            pc = pc + 4;
        end

        // load-use: lw then addu, one bubble
        drive(lw_i, pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        drive(addu_i, pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        drive(ori(9), pc, 1'b1, 1'b0, 1'b0); step();
        check_eq("lu_idex_bubble", IDEX_IR, 32'd0);
        check_eq("lu_ifid_keep", IFID_IR, addu_i);
        check_eq("lu_state", {30'd0, stall_state}, 32'd1);
        drive(ori(9), pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        check_eq("lu_idex_addu", IDEX_IR, addu_i);

        // hold with nop for 3 cycles, then bubble, then advance
        drive(lw_i, pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        drive(addu_i, pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        snap = IDEX_IR;
        for (int i = 0; i < 3; i++) begin
            drive(ori(3), pc, 1'b1, 1'b1, 1'b0);
            step();
            check_eq("hold_idex", IDEX_IR, snap);
            check_eq("hold_state", {30'd0, stall_state}, 32'd2);
        end
        drive(ori(3), pc, 1'b1, 1'b0, 1'b0); step();
        check_eq("rel_bubble", IDEX_IR, 32'd0);
        // nop stuck high in LDUSE inserts another bubble
        drive(ori(3), pc, 1'b1, 1'b0, 1'b0); step();
        check_eq("rel_bubble2", IDEX_IR, 32'd0);
        drive(ori(3), pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        check_eq("rel_advance", IDEX_IR, addu_i);

        // flush wins over hold and nop
        drive(ori(4), pc, 1'b1, 1'b1, 1'b1); step();
        check_eq("fl_ifid_ir", IFID_IR, 32'd0);
        check_eq("fl_idex_ir", IDEX_IR, 32'd0);
        check_eq("fl_ifid_pc", IFID_PC, 32'h3000);
        check_eq("fl_idex_pc", IDEX_PC, 32'h3000);
        check_eq("fl_state", {30'd0, stall_state}, 32'd0);

        // async reset mid-stall
        drive(ori(5), pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        drive(ori(6), pc, 1'b0, 1'b0, 1'b0); step(); pc = pc + 4;
        drive(ori(7), pc, 1'b1, 1'b1, 1'b0); step();
        reset = 1'b1;
        #2;
        check_eq("mid_rst_ifid_ir", IFID_IR, 32'd0);
        check_eq("mid_rst_idex_ir", IDEX_IR, 32'd0);
        check_eq("mid_rst_ifid_pc", IFID_PC, 32'h3000);
        check_eq("mid_rst_state", {30'd0, stall_state}, 32'd0);
        model_reset();
        reset = 1'b0;

        // random mix
        for (int i = 0; i < 80; i++) begin
            drive($urandom, pc,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 19) == 0));
            step();
            pc = pc + 4;
        end

`ifdef PIPE_PERF_CNT_EN
        drive(ori(0), pc, 1'b0, 1'b0, 1'b1); step();
        for (int i = 0; i < 5; i++) begin
            drive(ori(1), pc, 1'b1, 1'b0, 1'b0); step();
            drive(ori(1), pc, 1'b0, 1'b0, 1'b0); step();
        end
        for (int i = 0; i < 7; i++) begin
            drive(ori(2), pc, 1'b0, 1'b1, 1'b0); step();
        end
        check_eq("perf_bubble5", bubble_cnt, 32'd5);
        check_eq("perf_hold7", hold_cnt, 32'd7);
        drive(ori(2), pc, 1'b0, 1'b0, 1'b1); step();
        check_eq("perf_bubble_clr", bubble_cnt, 32'd0);
        check_eq("perf_hold_clr", hold_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
